// File: rtl/sram_req_arbiter.sv
// Two-master arbiter sharing one req/addr_ok/data_ok memory port between the
// instruction-fetch and load/store requesters. One outstanding transaction;
// data wins contests except after MAX_DATA_RUN consecutive contested data grants.
module sram_req_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic                clk,
    input  logic                reset,

    // Instruction-fetch requester
    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    // Load/store requester
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    // Shared memory port
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [3:0]  MaxRun = 4'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          run_cnt_q, run_cnt_d;
    logic                owner_q, owner_d;   // 1 = data requester owns the port
    logic                wr_q, wr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                pick_data;
    logic                grant;
    logic                resp;

    // Winner selection and same-cycle acceptance while idle
    always_comb begin
        pick_data    = data_req && !(inst_req && (run_cnt_q == MaxRun));
        grant        = (state_q == StIdle) && (inst_req || data_req) && !reset;
        inst_addr_ok = grant && !pick_data;
        data_addr_ok = grant && pick_data;
    end

    // Response routing; memory responses outside WAIT are ignored
    always_comb begin
        resp         = (state_q == StWait) && mem_data_ok && !reset;
        inst_data_ok = resp && !owner_q;
        data_data_ok = resp && owner_q;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Shared-port outputs come straight from the latched request and state flops
    always_comb begin
        mem_req   = (state_q == StReq);
        mem_wr    = wr_q;
        mem_wstrb = wstrb_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state_q != StIdle);
    end

    // Next-state, request latch and fairness counter
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StReq;
                    owner_d = pick_data;
                    if (pick_data) begin
                        wr_d    = data_wr;
                        wstrb_d = data_wstrb;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                        // Only contested data grants extend the run
                        if (inst_req) begin
                            run_cnt_d = (run_cnt_q == MaxRun) ? MaxRun : run_cnt_q + 4'd1;
                        end else begin
                            run_cnt_d = 4'd0;
                        end
                    end else begin
                        wr_d      = inst_wr;
                        wstrb_d   = inst_wstrb;
                        addr_d    = inst_addr;
                        wdata_d   = inst_wdata;
                        run_cnt_d = 4'd0;
                    end
                end
            end
            StReq: begin
                if (mem_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // All state registers; synchronous reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            run_cnt_q <= 4'd0;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: expected transactions are queued at
// grant time and compared against the shared port and the response pulses.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        bit          is_data;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sram_req_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_DATA_RUN(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_wr     (inst_wr),
        .inst_wstrb  (inst_wstrb),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_inst(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        inst_req = req; inst_wr = wr; inst_addr = addr; inst_wdata = wdata; inst_wstrb = wstrb;
    endtask

    task automatic set_data(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        data_req = req; data_wr = wr; data_addr = addr; data_wdata = wdata; data_wstrb = wstrb;
    endtask

    // In IDLE with requests driven: expect the given winner and queue its transaction
    task automatic grant(input bit exp_data, input bit drop, input logic [31:0] rd);
        txn_t e;
        smp();
        check("inst_addr_ok", inst_addr_ok, !exp_data);
        check("data_addr_ok", data_addr_ok, exp_data);
        check("busy_idle", busy, 0);
        check("mem_req_idle", mem_req, 0);
        e.is_data = exp_data;
        if (exp_data) begin
            e.wr = data_wr; e.addr = data_addr; e.wdata = data_wdata; e.wstrb = data_wstrb;
        end else begin
            e.wr = inst_wr; e.addr = inst_addr; e.wdata = inst_wdata; e.wstrb = inst_wstrb;
        end
        e.rd = rd;
        sb.push_back(e);
        step();
        if (drop) begin
            if (exp_data) data_req = 1'b0;
            else          inst_req = 1'b0;
        end
    endtask

    // Memory side: a_dly extra REQ cycles, d_dly extra WAIT cycles, optional spurious data_ok in REQ
    task automatic serve(input int a_dly, input int d_dly, input bit spur);
        txn_t e;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb[0];
        for (int k = 0; k <= a_dly; k++) begin
            mem_addr_ok = (k == a_dly);
            mem_data_ok = spur && (k != a_dly);
            smp();
            check("mem_req", mem_req, 1);
            check("mem_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata},
                  {e.wr, e.wstrb, e.addr, e.wdata});
            check("busy_req", busy, 1);
            check("quiet_req", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 0);
            step();
        end
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        for (int k = 0; k < d_dly; k++) begin
            smp();
            check("mem_req_wait", mem_req, 0);
            check("quiet_wait", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 0);
            check("busy_wait", busy, 1);
            step();
        end
        mem_data_ok = 1'b1;
        mem_rdata   = e.rd;
        smp();
        e = sb.pop_front();
        check("data_ok", {inst_data_ok, data_data_ok}, {!e.is_data, e.is_data});
        if (!e.wr) check("rdata", e.is_data ? data_rdata : inst_rdata, e.rd);
        step();
        mem_data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_inst(0, 0, 0, 0, 0);
        set_data(0, 0, 0, 0, 0);
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        step();
        step();
        reset = 1'b0;
        smp();
        check("reset_outs", {mem_req, busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        check("reset_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
        step();

        // Single instruction read, one-cycle memory handshakes
        set_inst(1, 0, 32'h1c00_0000, 0, 0);
        grant(0, 1, 32'h0280_0421);
        serve(0, 0, 0);

        // Data write with three extra cycles before mem_addr_ok
        set_data(1, 1, 32'h0000_1000, 32'hdead_beef, 4'hf);
        grant(1, 1, 0);
        serve(3, 0, 0);
        smp();
        check("idle_after_write", {busy, inst_data_ok, data_data_ok}, 0);
        step();

        // Both requesting continuously: D,D,D,D,I repeated, then two more grants
        set_inst(1, 0, 32'h1c00_0040, 0, 0);
        set_data(1, 0, 32'h0000_2000, 0, 0);
        for (int i = 0; i < 12; i++) begin
            grant((i % 5) != 4, 0, 32'h1000_0000 + i);
            serve(0, i % 2, 0);
        end
        inst_req = 1'b0;

        // Uncontested data grants clear the run, so a fresh contest allows four data first
        for (int i = 0; i < 6; i++) begin
            grant(1, 0, 32'h2000_0000 + i);
            serve(0, 0, 0);
        end
        inst_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            grant(i != 4, 0, 32'h3000_0000 + i);
            serve(0, 0, 0);
        end
        inst_req = 1'b0;
        data_req = 1'b0;

        // Spurious mem_data_ok in IDLE
        mem_data_ok = 1'b1;
        smp();
        check("spur_idle", {inst_data_ok, data_data_ok, busy, mem_req}, 0);
        step();
        mem_data_ok = 1'b0;
        smp();
        check("spur_idle_after", {busy, mem_req}, 0);
        step();

        // Spurious mem_data_ok during REQ
        set_inst(1, 0, 32'h1c00_0100, 0, 0);
        grant(0, 1, 32'h4444_5555);
        serve(2, 1, 1);

        // Reset while waiting for the response
        set_data(1, 0, 32'h0000_3000, 32'h1234_5678, 4'h3);
        grant(1, 1, 32'h5555_6666);
        mem_addr_ok = 1'b1;
        smp();
        check("rst_req_phase", mem_req, 1);
        step();
        mem_addr_ok = 1'b0;
        smp();
        check("rst_in_wait", {busy, mem_req}, 2'b10);
        step();
        reset = 1'b1;
        sb.delete();
        smp();
        check("rst_cycle_no_resp", {inst_data_ok, data_data_ok}, 0);
        step();
        reset = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5555_6666;
        smp();
        check("post_rst_outs", {mem_req, busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        check("post_rst_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
        step();
        mem_data_ok = 1'b0;
        smp();
        check("post_rst_idle", {busy, inst_data_ok, data_data_ok}, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-master arbiter that shares one request/response memory port between the instruction-fetch requester and the load/store requester of the pipelined core. It accepts one transaction at a time from either side, drives it onto the shared port with a req/addr_ok/data_ok handshake, and routes the response back to the owner. Data accesses have priority, with a bounded-run fairness rule so fetch cannot starve.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_RUN, 4, max consecutive contested data grants before inst is forced (1..15)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req / data_req  in  1  request valid, held until matching *_addr_ok
- inst_wr / data_wr  in  1  1=write, 0=read
- inst_wstrb / data_wstrb  in  DATA_W/8  byte enables (writes)
- inst_addr / data_addr  in  ADDR_W  address
- inst_wdata / data_wdata  in  DATA_W  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response valid this cycle (reads and writes)
- inst_rdata / data_rdata  out  DATA_W  read data, valid with *_data_ok
- mem_req  out  1  shared-port request
- mem_wr, mem_wstrb, mem_addr, mem_wdata  out  —  latched request fields
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE, REQ, WAIT. One outstanding transaction total.
- IDLE: if any *_req, choose winner; assert winner's *_addr_ok combinationally same cycle; latch wr/wstrb/addr/wdata and owner bit; go REQ. No req: stay.
- Winner: data only -> data; inst only -> inst; both -> data unless run_cnt == MAX_DATA_RUN, then inst.
- run_cnt (4 bits): data grant while inst_req=1 -> +1; data grant while inst_req=0 -> 0; inst grant -> 0. Saturates at MAX_DATA_RUN.
- REQ: mem_req=1 with latched fields (stable) until mem_addr_ok; on mem_addr_ok go WAIT.
- WAIT: mem_req=0; on mem_data_ok assert owner's *_data_ok for that cycle, *_rdata = mem_rdata; go IDLE.
- mem_data_ok outside WAIT is ignored (no output pulse). Memory must not return data_ok in the same cycle as addr_ok.
- Non-owner *_data_ok is never asserted; *_addr_ok never asserted outside IDLE.
- inst_rdata and data_rdata both wire to mem_rdata; meaningful only with respective data_ok.
- Write responses: data_ok pulses normally; rdata is don't-care.

## Timing
- Reset: state IDLE, run_cnt 0, owner 0, latched fields 0; mem_req, all *_addr_ok, all *_data_ok, busy = 0.
- Reset mid-transaction: in-flight transaction abandoned, no data_ok issued; memory is reset by same reset.
- Best case (req at t in IDLE, mem_addr_ok at t+1, mem_data_ok at t+2): addr_ok at t, mem_req at t+1, data_ok at t+2, IDLE at t+3, next addr_ok at t+3 earliest. Throughput 1 transaction / 3 cycles.
- Each extra cycle of mem_addr_ok or mem_data_ok delay adds one cycle; no timeout.
- Requester deasserting *_req before addr_ok is allowed; request simply not taken (decision uses current-cycle req only).
- Simultaneous mem_addr_ok in IDLE/WAIT: ignored.

## Test plan
- Single inst read 0x1c000000, memory returns 0x02800421 with addr_ok/data_ok one cycle each -> inst_addr_ok at t, mem_req at t+1 with mem_addr=0x1c000000, inst_data_ok at t+2 with rdata 0x02800421, data_data_ok stays 0.
- Data write addr 0x00001000 wdata 0xdeadbeef wstrb 0xf, memory delays addr_ok 3 cycles -> mem fields stable for all 4 req cycles, data_data_ok once after data_ok, busy high throughout.
- Both requesting continuously, MAX_DATA_RUN=4 -> grant order D,D,D,D,I,D,D,D,D,I…; never more than 4 contested data grants in a row.
- Data only requesting for 6 transactions, then both -> run_cnt 0 on first contest, four data grants before inst.
- Reset asserted in WAIT -> next cycle all outputs 0, state IDLE; a late mem_data_ok produces no *_data_ok.
- Spurious mem_data_ok in IDLE and REQ -> no *_data_ok pulses, FSM unchanged.
